// File: rtl/click_sequencer.sv
// Button-action sequencer: moves the cursor and issues reveal/flag
// commands to the board over a valid/ready handshake.
module click_sequencer #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int ROW_W = 3,
  parameter int COL_W = 3,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [2:0]       action,
  input  logic             game_over,
  input  logic             cmd_ready,
  output logic             ack,
  output logic             cmd_valid,
  output logic             cmd_op,
  output logic [ROW_W-1:0] cmd_row,
  output logic [COL_W-1:0] cmd_col,
  output logic [ROW_W-1:0] cursor_row,
  output logic [COL_W-1:0] cursor_col,
  output logic             busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_EXEC = 3'd1;
  localparam logic [2:0] S_CMD  = 3'd2;
  localparam logic [2:0] S_ACK  = 3'd3;
  localparam logic [2:0] S_REL  = 3'd4;

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);

  logic [2:0]       state;
  logic [2:0]       state_n;
  logic [2:0]       act_q;
  logic [ROW_W-1:0] row_n;
  logic [COL_W-1:0] col_n;
  logic             is_click;

  assign is_click = (act_q == 3'b001) || (act_q == 3'b010);

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (action != 3'b000) state_n = S_EXEC;
      S_EXEC: state_n = (is_click && !game_over) ? S_CMD : S_ACK;
      S_CMD:  if (cmd_ready) state_n = S_ACK;
      S_ACK:  state_n = S_REL;
      S_REL:  if (action == 3'b000) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Edge compare against ROWS-1/COLS-1 keeps non-power-of-two boards correct
  always_comb begin
    row_n = cursor_row;
    col_n = cursor_col;
    if (state == S_EXEC) begin
      unique case (act_q)
        3'b100:
          row_n = (cursor_row == '0)
                ? (WRAP ? ROW_MAX : cursor_row)
                : cursor_row - 1'b1;
        3'b110:
          row_n = (cursor_row == ROW_MAX)
                ? (WRAP ? '0 : cursor_row)
                : cursor_row + 1'b1;
        3'b111:
          col_n = (cursor_col == '0)
                ? (WRAP ? COL_MAX : cursor_col)
                : cursor_col - 1'b1;
        3'b101:
          col_n = (cursor_col == COL_MAX)
                ? (WRAP ? '0 : cursor_col)
                : cursor_col + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state      <= S_IDLE;
      act_q      <= 3'b000;
      ack        <= 1'b0;
      busy       <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_op     <= 1'b0;
      cmd_row    <= '0;
      cmd_col    <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
    end else begin
      state      <= state_n;
      busy       <= (state_n != S_IDLE);
      ack        <= (state_n == S_ACK);
      cursor_row <= row_n;
      cursor_col <= col_n;
      if (state == S_IDLE && action != 3'b000)
        act_q <= action;
      if (state == S_EXEC && state_n == S_CMD) begin
        cmd_valid <= 1'b1;
        cmd_op    <= (act_q == 3'b010);
        cmd_row   <= cursor_row;
        cmd_col   <= cursor_col;
      end else if (state == S_CMD && cmd_ready) begin
        cmd_valid <= 1'b0;
      end
    end
  end

endmodule
